// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared definitions for the execute stage: bus widths,
//               ALU operation / result-class codes, divider state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // Bus widths shared with decode and EX/MEM
  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;
  localparam int ALU_SEL_BUS  = 3;

  // ALU operation codes
  localparam logic [ALU_OP_BUS-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALU_OP_BUS-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALU_OP_BUS-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALU_OP_BUS-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALU_OP_BUS-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [ALU_OP_BUS-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALU_OP_BUS-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [ALU_OP_BUS-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_BUS-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // Result classes
  localparam logic [ALU_SEL_BUS-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_BUS-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_BUS-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_BUS-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALU_SEL_BUS-1:0] EXE_RES_DIV   = 3'b101;

  // Iterative divider states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // True when the decoded bundle requests a division
  function automatic logic is_div_op(input logic [ALU_SEL_BUS-1:0] sel,
                                     input logic [ALU_OP_BUS-1:0]  op);
    return (sel == EXE_RES_DIV) && ((op == EXE_DIV_OP) || (op == EXE_DIVU_OP));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative restoring divider, one quotient bit per cycle.
//               Operands are reduced to magnitudes on start; the sign is
//               reapplied to the quotient on the result port.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            annul,
  input  logic            hold,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int               CNT_W     = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             neg_q, neg_d;

  // Shifted partial remainder and trial subtraction; bit XLEN of diff is the borrow
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state, shift-subtract step and handshake outputs; annul overrides all
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
    stall_req = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          rem_d     = '0;
          cnt_d     = '0;
          quo_d     = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
          dvs_d     = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
          neg_d     = signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
          state_d   = DIV_BUSY;
          if (divisor == '0) begin
            // Divide-by-zero: all-ones quotient, never sign-corrected
            quo_d   = '1;
            neg_d   = 1'b0;
            state_d = DIV_DONE;
          end
        end
      end
      DIV_BUSY: begin
        stall_req = 1'b1;
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done = 1'b1;
        if (!hold) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (annul) begin
      state_d   = DIV_IDLE;
      stall_req = 1'b0;
      done      = 1'b0;
    end
  end

  assign result = neg_q ? -quo_q : quo_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage. Combinational ALU for single-cycle ops, an
//               iterative divider for DIV/DIVU, and gating of the write-back
//               bundle that also feeds EX forwarding in decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_BUS-1:0]   aluop_i,
  input  logic [ALU_SEL_BUS-1:0]  alusel_i,
  input  logic [XLEN-1:0]         reg1_i,
  input  logic [XLEN-1:0]         reg2_i,
  input  logic [REG_ADDR_BUS-1:0] wd_i,
  input  logic                    wreg_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [REG_ADDR_BUS-1:0] wd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         wdata_o,
  output logic                    stall_req_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               alu_ok;
  logic               is_div;
  logic               div_stall;
  logic               div_done;
  logic [XLEN-1:0]    div_result;

  assign shamt  = reg2_i[SHAMT_W-1:0];
  assign is_div = is_div_op(alusel_i, aluop_i);

  div_iter #(
    .XLEN      (XLEN),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (aluop_i == EXE_DIV_OP),
    .annul     (flush_i),
    .hold      (stall_i),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .stall_req (div_stall),
    .done      (div_done),
    .result    (div_result)
  );

  // Single-cycle ALU; alu_ok is low for NOP and any unrecognised op
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b0;
    unique case (alusel_i)
      EXE_RES_LOGIC: begin
        alu_ok = 1'b1;
        unique case (aluop_i)
          EXE_OR_OP:  alu_res = reg1_i | reg2_i;
          EXE_AND_OP: alu_res = reg1_i & reg2_i;
          EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
          EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
          default:    alu_ok  = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        alu_ok = 1'b1;
        unique case (aluop_i)
          EXE_SLL_OP: alu_res = reg1_i << shamt;
          EXE_SRL_OP: alu_res = reg1_i >> shamt;
          EXE_SRA_OP: alu_res = $signed(reg1_i) >>> shamt;
          default:    alu_ok  = 1'b0;
        endcase
      end
      EXE_RES_ARITH: begin
        alu_ok = 1'b1;
        unique case (aluop_i)
          EXE_ADD_OP:  alu_res = reg1_i + reg2_i;
          EXE_SUB_OP:  alu_res = reg1_i - reg2_i;
          EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, (reg1_i < reg2_i)};
          default:     alu_ok  = 1'b0;
        endcase
      end
      default: begin
        alu_ok = 1'b0;
      end
    endcase
  end

  // Write-back bundle: reset forces zero, flush annuls, divider results only when done
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    if (rst) begin
      wd_o = '0;
    end else if (!flush_i) begin
      stall_req_o = div_stall;
      if (div_done) begin
        wreg_o  = wreg_i;
        wdata_o = div_result;
      end else if (!div_stall && !is_div && alu_ok) begin
        wreg_o  = wreg_i;
        wdata_o = alu_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Scoreboard bench for ex_stage. Stimulus pushes expected
//               write-back bundles; a monitor pops one per cycle in which
//               the stage presents wreg_o=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;

  typedef struct packed {
    logic [4:0]  wd;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ex_stage #(
    .XLEN      (32),
    .DIV_STEPS (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented write is matched against the scoreboard head
  always @(negedge clk) begin
    if (wreg_o !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wreg_o=%b wd=%0d wdata=%h, required no write",
                 wreg_o, wd_o, wdata_o);
      end else begin
        mon_e = sb.pop_front();
        if (wd_o !== mon_e.wd || wdata_o !== mon_e.wdata) begin
          errors++;
          $display("FAIL wb_bundle: got wd=%0d wdata=%h, required wd=%0d wdata=%h",
                   wd_o, wdata_o, mon_e.wd, mon_e.wdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = d;
    wreg_i   = w;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    apply(8'h00, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  // Single-cycle op expected to write back in the same cycle
  task automatic alu(input string name, input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                     input logic [31:0] exp);
    apply(op, sel, a, b, d, 1'b1);
    sb.push_back('{wd: d, wdata: exp});
    obs();
    check({name, "_stall"}, {31'b0, stall_req_o}, 32'h0);
    adv();
  endtask

  // Op that must not write back
  task automatic no_write(input string name, input logic [7:0] op, input logic [2:0] sel);
    apply(op, sel, 32'h1234_5678, 32'h0000_00FF, 5'd9, 1'b1);
    obs();
    check({name, "_wreg"}, {31'b0, wreg_o}, 32'h0);
    check({name, "_wdata"}, wdata_o, 32'h0);
    adv();
  endtask

  // Division: counts stalled cycles, then holds DONE for hold_cycles total
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp,
                         input int exp_stall, input int hold_cycles);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    apply(op, EXE_RES_DIV, a, b, d, 1'b1);
    for (int i = 0; i < hold_cycles; i++) sb.push_back('{wd: d, wdata: exp});
    obs();
    while (stall_req_o === 1'b1 && n < 40) begin
      n++;
      if (wreg_o !== 1'b0) bad++;
      adv();
      obs();
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    check({name, "_gated_wreg"}, bad, 0);
    if (hold_cycles > 1) begin
      stall_i = 1'b1;
      for (int i = 1; i < hold_cycles; i++) begin
        adv();
        obs();
        check({name, "_hold_stall"}, {31'b0, stall_req_o}, 32'h0);
      end
      stall_i = 1'b0;
    end
    adv();
    idle_in();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, required finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    apply(EXE_ADD_OP, EXE_RES_ARITH, 32'h1, 32'h2, 5'd4, 1'b1);
    adv();
    adv();
    // Outputs forced to zero during reset even with a live instruction
    obs();
    check("rst_wreg", {31'b0, wreg_o}, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_wd", {27'b0, wd_o}, 32'h0);
    check("rst_stall", {31'b0, stall_req_o}, 32'h0);
    adv();
    rst = 1'b0;
    idle_in();
    adv();

    // Single-cycle ALU operations
    alu("add_wrap", EXE_ADD_OP,  EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 32'h8000_0000);
    alu("slt",      EXE_SLT_OP,  EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd6, 32'h0000_0000);
    alu("slt_neg",  EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 32'h0000_0001);
    alu("sltu",     EXE_SLTU_OP, EXE_RES_ARITH, 32'h0000_0001, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);
    alu("sub",      EXE_SUB_OP,  EXE_RES_ARITH, 32'h0000_0005, 32'h0000_0007, 5'd8, 32'hFFFF_FFFE);
    alu("sra",      EXE_SRA_OP,  EXE_RES_SHIFT, 32'h8000_0010, 32'h0000_0004, 5'd10, 32'hF800_0001);
    alu("srl",      EXE_SRL_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'h0000_0004, 5'd11, 32'h0800_0000);
    alu("sll",      EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0001, 32'h0000_0023, 5'd12, 32'h0000_0008);
    alu("nor",      EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_0000, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF);
    alu("and",      EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd14, 32'h00F0_00F0);
    alu("xor",      EXE_XOR_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd15, 32'hFF00_FF00);
    alu("or",       EXE_OR_OP,   EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_5678, 5'd16, 32'h1234_5678);
    no_write("nop", 8'h00, EXE_RES_NOP);
    no_write("unknown_op", 8'hFF, EXE_RES_LOGIC);
    idle_in();

    // Divider: magnitude, sign, divide-by-zero, overflow, held result
    run_div("div_neg",   EXE_DIV_OP,  32'hFFFF_FF9C, 32'h0000_0007, 5'd3,  32'hFFFF_FFF2, 33, 1);
    run_div("divu",      EXE_DIVU_OP, 32'h0000_0064, 32'h0000_0007, 5'd3,  32'h0000_000E, 33, 1);
    run_div("div_negd",  EXE_DIV_OP,  32'h0000_0064, 32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 33, 1);
    run_div("divu_zero", EXE_DIVU_OP, 32'h0000_0005, 32'h0000_0000, 5'd18, 32'hFFFF_FFFF, 1, 1);
    run_div("div_zero",  EXE_DIV_OP,  32'hFFFF_FFFB, 32'h0000_0000, 5'd19, 32'hFFFF_FFFF, 1, 1);
    run_div("div_ovf",   EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 33, 1);
    run_div("div_hold",  EXE_DIVU_OP, 32'h0000_03E8, 32'h0000_000A, 5'd21, 32'h0000_0064, 33, 3);

    // Flush during BUSY step 10, then a normal OR
    apply(EXE_DIV_OP, EXE_RES_DIV, 32'h0000_0064, 32'h0000_0007, 5'd22, 1'b1);
    obs();
    adv();
    for (int i = 0; i < 10; i++) begin
      obs();
      adv();
    end
    flush_i = 1'b1;
    obs();
    check("flush_stall", {31'b0, stall_req_o}, 32'h0);
    check("flush_wreg", {31'b0, wreg_o}, 32'h0);
    adv();
    flush_i = 1'b0;
    alu("or_after_flush", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd23, 32'h0000_00FF);
    idle_in();

    // Reset during BUSY
    apply(EXE_DIVU_OP, EXE_RES_DIV, 32'h0000_0064, 32'h0000_0007, 5'd24, 1'b1);
    obs();
    adv();
    for (int i = 0; i < 5; i++) begin
      obs();
      adv();
    end
    rst = 1'b1;
    obs();
    check("rst_busy_wreg", {31'b0, wreg_o}, 32'h0);
    check("rst_busy_wdata", wdata_o, 32'h0);
    check("rst_busy_wd", {27'b0, wd_o}, 32'h0);
    check("rst_busy_stall", {31'b0, stall_req_o}, 32'h0);
    adv();
    rst = 1'b0;
    idle_in();
    obs();
    check("post_rst_stall", {31'b0, stall_req_o}, 32'h0);
    adv();
    alu("add_after_rst", EXE_ADD_OP, EXE_RES_ARITH, 32'h0000_0010, 32'h0000_0020, 5'd25, 32'h0000_0030);
    idle_in();
    adv();

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
